i2c_master_entity: RTL and testbench
====================================

Name: i2c_master_entity

Overview:
- Single-channel I2C master for one ToF sensor; one instance per sensor channel, commanded by the per-channel ToF control FSM.
- Performs register writes and reads using a 16-bit register address. Drives open-drain SCL/SDA through external tri-state pad buffers.
- Reports completion on `ready`, slave NACK on `error_out`, and the last two read bytes on `data_out`.

Parameters:
- CLK_DIV, 250, number of `clock` cycles per quarter SCL period (100 kHz SCL at 100 MHz).
- ADDR_W, 16, register address width; must be a multiple of 8; sent MSB byte first.

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  command request; sampled only while ready=1
- slave_adress  in  7  7-bit slave address
- register_address  in  16  target register index
- is_read  in  1  1 = read transaction, 0 = write transaction
- nb_of_bytes  in  10  data byte count (0..1023)
- data_in  in  8  write data byte
- data_out  out  16  last two bytes read; most recent byte in [7:0]
- ready  out  1  1 = idle and able to accept a command
- error_out  out  1  slave NACK seen in the last transaction
- SCL_in  out  1  pad drive value for SCL; constant 0
- SDA_in  out  1  pad drive value for SDA; constant 0
- SCL_t  out  1  SCL tri-state: 1 = release (high via pull-up), 0 = pull low
- SDA_t  out  1  SDA tri-state, same encoding as SCL_t
- SCL_out  in  1  sampled SCL pad level
- SDA_out  in  1  sampled SDA pad level

Behaviour:
- Reset (async, active-high):
  - ready=1, error_out=0, data_out=0, SCL_t=1, SDA_t=1.
  - FSM goes to IDLE and the tick divider clears.
  - A reset asserted mid-transaction aborts it immediately and releases both lines; no STOP is generated.
- Command capture: `ready=1` and `start=1` on a clock edge latches slave_adress, register_address, is_read and nb_of_bytes. On the same edge: ready=0 and error_out=0. `start` is ignored while ready=0.
- Timing: a tick occurs every CLK_DIV clocks. Each bit takes 4 ticks:
  - tick 0: SDA changes while SCL is low.
  - tick 1: SCL released.
  - tick 2: SDA sampled while SCL is high.
  - tick 3: SCL pulled low.
- States: IDLE, START, ADDR_W, REG_HI, REG_LO, WR_DATA, RESTART, ADDR_R, RD_DATA, STOP. After each transmitted byte comes a 9th (ACK) bit; the master releases SDA and samples it.
- START: SDA falls while SCL is high, then SCL falls.
- Write sequence: START, {addr,0}, REG_HI, REG_LO, then nb_of_bytes WR_DATA bytes, then STOP.
  - data_in is sampled at tick 0 of bit 7 of each data byte, so the commander may change it between bytes.
  - nb_of_bytes=0 sends the address phase only.
- Read sequence: START, {addr,0}, REG_HI, REG_LO, RESTART, {addr,1}, then nb_of_bytes RD_DATA bytes, then STOP.
  - Each received byte shifts into data_out: data_out <= {data_out[7:0], byte}.
  - The master drives ACK (SDA low) after each byte except the last, which gets NACK (SDA released).
  - Read with nb_of_bytes=0: STOP after REG_LO; no restart.
- NACK: a sampled SDA=1 in any slave ACK slot sets error_out=1 and jumps to STOP. error_out holds until the next accepted start.
- STOP: SDA low, SCL released, then SDA released. One tick later ready=1.
- Bit order: MSB first everywhere.
- Byte counter is 10 bits and counts down; no wrap-around is possible.

Optional Feature:
- Macro: I2C_CLK_STRETCH_EN.
- Defined: after SCL is released at tick 1, the tick divider is held until SCL_out reads 1, which supports slave clock stretching.
- Not defined: SCL_out is ignored and timing is purely counter-based.

Test Plan:
- Reset mid-read → within 1 clock SCL_t=1, SDA_t=1, ready=1, error_out=0, data_out=0.
- Write: CLK_DIV=4, slave 0x29, reg 0x1234, nb=2, data_in 0xA5 then 0x5A, slave ACKs → bus carries 0x52, 0x12, 0x34, 0xA5, 0x5A, then STOP; ready returns to 1; error_out=0.
- Read: reg 0x0001, nb=2, slave returns 0xBE, 0xEF → bus shows restart and 0x53; master ACKs the first byte and NACKs the second; data_out=0xBEEF.
- Address NACK (SDA high in the first ACK slot) → STOP immediately with no register bytes; error_out=1 and ready=1 until the next start.
- `start` held high while busy → no second transaction until ready=1. With nb=0 write → bus carries only 0x52, 0x12, 0x34 and STOP.
- With I2C_CLK_STRETCH_EN defined, slave holds SCL low 20 clocks at bit 3 → that bit's high phase is delayed by 20 clocks; data is still correct.

Source files
------------

// File: rtl/i2c_master_entity.sv
// i2c_master_entity: single-channel I2C master doing 16-bit-indexed register writes and reads.
// Optional feature macro: I2C_CLK_STRETCH_EN (holds bit timing while a slave stretches SCL).
module i2c_master_entity #(
   parameter int CLK_DIV = 250,
   parameter int ADDR_W  = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [6:0]        slave_adress,
   input  logic [ADDR_W-1:0] register_address,
   input  logic              is_read,
   input  logic [9:0]        nb_of_bytes,
   input  logic [7:0]        data_in,
   output logic [15:0]       data_out,
   output logic              ready,
   output logic              error_out,
   output logic              SCL_in,
   output logic              SDA_in,
   output logic              SCL_t,
   output logic              SDA_t,
   input  logic              SCL_out,
   input  logic              SDA_out
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int RB = ADDR_W / 8;

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_ADDR_W, S_REG_HI, S_REG_LO,
      S_WR_DATA, S_RESTART, S_ADDR_R, S_RD_DATA, S_STOP
   } state_t;

   state_t            state_q, state_d;
   logic [DW-1:0]     div_q, div_d;
   logic [1:0]        ph_q, ph_d;
   logic [3:0]        bit_q, bit_d;
   logic [7:0]        sh_q, sh_d;
   logic [ADDR_W-1:0] reg_q, reg_d;
   logic [3:0]        rb_q, rb_d;
   logic [9:0]        cnt_q, cnt_d;
   logic [6:0]        addr_q, addr_d;
   logic              rd_q, rd_d;
   logic              scl_q, scl_d;
   logic              sda_q, sda_d;
   logic              rdy_q, rdy_d;
   logic              err_q, err_d;
   logic [15:0]       dout_q, dout_d;

   logic       stall, tick, is_tx, ack_bit, is_reg;
   logic [7:0] src, tx;

`ifdef I2C_CLK_STRETCH_EN
   assign stall = (ph_q == 2'd2) && !SCL_out;
`else
   logic unused_scl;
   assign unused_scl = SCL_out;
   assign stall = 1'b0;
`endif

   assign tick    = (state_q != S_IDLE) && (div_q == DW'(CLK_DIV - 1)) && !stall;
   assign is_reg  = (state_q == S_REG_HI) || (state_q == S_REG_LO);
   assign is_tx   = (state_q == S_ADDR_W) || is_reg || (state_q == S_WR_DATA) || (state_q == S_ADDR_R);
   assign ack_bit = (bit_q == 4'd8);
   assign src     = (state_q == S_ADDR_W)  ? {addr_q, 1'b0} :
                    (state_q == S_ADDR_R)  ? {addr_q, 1'b1} :
                    (state_q == S_WR_DATA) ? data_in : reg_q[ADDR_W-1 -: 8];
   assign tx      = (bit_q == 4'd0) ? src : sh_q;

   assign data_out  = dout_q;
   assign ready     = rdy_q;
   assign error_out = err_q;
   assign SCL_in    = 1'b0;
   assign SDA_in    = 1'b0;
   assign SCL_t     = scl_q;
   assign SDA_t     = sda_q;

   // Bit sequencer: each tick advances one quarter of the current bit, ACK slot is bit 8
   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      reg_d   = reg_q;
      rb_d    = rb_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      rd_d    = rd_q;
      scl_d   = scl_q;
      sda_d   = sda_q;
      rdy_d   = rdy_q;
      err_d   = err_q;
      dout_d  = dout_q;
      div_d   = (state_q == S_IDLE || tick) ? '0 : stall ? div_q : div_q + DW'(1);
      if (state_q == S_IDLE) begin
         if (start) begin
            addr_d  = slave_adress;
            reg_d   = register_address;
            rd_d    = is_read;
            cnt_d   = nb_of_bytes;
            rb_d    = 4'(RB);
            rdy_d   = 1'b0;
            err_d   = 1'b0;
            ph_d    = 2'd0;
            bit_d   = 4'd0;
            state_d = S_START;
         end
      end else if (tick) begin
         ph_d = ph_q + 2'd1;
         if (ph_q == 2'd1) scl_d = 1'b1;
         if (ph_q == 2'd3) scl_d = (state_q == S_STOP);
         if (state_q == S_START || state_q == S_RESTART) begin
            if (ph_q == 2'd0) sda_d = 1'b1;
            if (ph_q == 2'd2) sda_d = 1'b0;
            if (ph_q == 2'd3) begin
               bit_d   = 4'd0;
               state_d = (state_q == S_START) ? S_ADDR_W : S_ADDR_R;
            end
         end else if (state_q == S_STOP) begin
            if (ph_q == 2'd0) sda_d = 1'b0;
            if (ph_q == 2'd2) sda_d = 1'b1;
            if (ph_q == 2'd3) begin
               rdy_d   = 1'b1;
               state_d = S_IDLE;
            end
         end else begin
            if (ph_q == 2'd0) begin
               if (!ack_bit) begin
                  sda_d = is_tx ? tx[7] : 1'b1;
                  sh_d  = is_tx ? {tx[6:0], 1'b0} : sh_q;
                  reg_d = (bit_q == 4'd0 && is_reg) ? reg_q << 8 : reg_q;
               end else begin
                  sda_d  = is_tx || (cnt_q == 10'd1);
                  dout_d = is_tx ? dout_q : {dout_q[7:0], sh_q};
               end
            end
            if (ph_q == 2'd2) begin
               if (!is_tx && !ack_bit) sh_d = {sh_q[6:0], SDA_out};
               if (is_tx && ack_bit && SDA_out) err_d = 1'b1;
            end
            if (ph_q == 2'd3) begin
               bit_d = ack_bit ? 4'd0 : bit_q + 4'd1;
               if (ack_bit) begin
                  if (err_q) state_d = S_STOP;
                  else begin
                     case (state_q)
                        S_ADDR_W: state_d = (RB > 1) ? S_REG_HI : S_REG_LO;
                        S_REG_HI: begin
                           rb_d    = rb_q - 4'd1;
                           state_d = (rb_q == 4'd2) ? S_REG_LO : S_REG_HI;
                        end
                        S_REG_LO: state_d = (cnt_q == 10'd0) ? S_STOP : rd_q ? S_RESTART : S_WR_DATA;
                        S_ADDR_R: state_d = S_RD_DATA;
                        default: begin
                           cnt_d   = cnt_q - 10'd1;
                           state_d = (cnt_q == 10'd1) ? S_STOP : state_q;
                        end
                     endcase
                  end
               end
            end
         end
      end
   end

   // State registers; reset releases both lines and aborts without a STOP
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         div_q   <= '0;
         ph_q    <= 2'd0;
         bit_q   <= 4'd0;
         sh_q    <= 8'd0;
         reg_q   <= '0;
         rb_q    <= 4'd0;
         cnt_q   <= 10'd0;
         addr_q  <= 7'd0;
         rd_q    <= 1'b0;
         scl_q   <= 1'b1;
         sda_q   <= 1'b1;
         rdy_q   <= 1'b1;
         err_q   <= 1'b0;
         dout_q  <= 16'd0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         ph_q    <= ph_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         reg_q   <= reg_d;
         rb_q    <= rb_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         rd_q    <= rd_d;
         scl_q   <= scl_d;
         sda_q   <= sda_d;
         rdy_q   <= rdy_d;
         err_q   <= err_d;
         dout_q  <= dout_d;
      end
   end

endmodule

// File: tb/tb_i2c_master_entity.sv
// tb_i2c_master_entity: directed bench with a bus-level slave model logging START/STOP/bytes/master ACKs.
module tb_i2c_master_entity;

   localparam int EV_S   = 'h100;
   localparam int EV_P   = 'h200;
   localparam int EV_ACK = 'h300;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [6:0]  sa = 7'h29;
   logic [15:0] ra = 16'h0;
   logic        rd = 1'b0;
   logic [9:0]  nb = 10'd0;
   logic [7:0]  di = 8'h0;
   logic [15:0] dout;
   logic        rdy, err, scl_i, sda_i, scl_t, sda_t;
   logic        drv = 1'b1;
   logic        scl, sda;

   int         n_tests = 0;
   int         n_fail = 0;
   int         log_q[$];
   int         exp_q[$];
   int         nbytes = 0;
   bit         nack_addr = 1'b0;
   logic [7:0] rdb[4];

   assign scl = scl_t;
   assign sda = sda_t & drv;

   i2c_master_entity #(.CLK_DIV(4), .ADDR_W(16)) dut (
      .clock(clk), .reset(rst), .start(start), .slave_adress(sa),
      .register_address(ra), .is_read(rd), .nb_of_bytes(nb), .data_in(di),
      .data_out(dout), .ready(rdy), .error_out(err),
      .SCL_in(scl_i), .SDA_in(sda_i), .SCL_t(scl_t), .SDA_t(sda_t),
      .SCL_out(scl), .SDA_out(sda)
   );

   always #5 clk = ~clk;

   // Slave model: watches the bus on the falling clock edge, away from the DUT's sampling edge
   logic       ps = 1'b1, pd = 1'b1, first = 1'b0, mack = 1'b0;
   int         bc = 0, mode = 0, ti = 0;
   logic [7:0] rsh = 8'h0, tsh = 8'h0;
   always @(negedge clk) begin
      if (ps && scl && pd && !sda) begin
         log_q.push_back(EV_S);
         mode = 1; bc = 0; first = 1'b1; ti = 0;
      end else if (ps && scl && !pd && sda) begin
         log_q.push_back(EV_P);
         mode = 0;
      end else if (!ps && scl) begin
         bc++;
         if (mode == 1 && bc <= 8) begin
            rsh = {rsh[6:0], sda};
            if (bc == 8) begin
               log_q.push_back(int'(rsh));
               nbytes++;
            end
         end
         if (mode == 2 && bc == 9) begin
            mack = sda;
            log_q.push_back(EV_ACK | int'(sda));
         end
      end else if (ps && !scl) begin
         if (mode == 1) begin
            if (bc == 8) drv = (first && nack_addr) ? 1'b1 : 1'b0;
            else if (bc == 9) begin
               drv = 1'b1; bc = 0;
               if (first && rsh[0]) begin
                  mode = 2; tsh = rdb[ti % 4]; ti++; drv = tsh[7];
               end
               first = 1'b0;
            end
         end else if (mode == 2) begin
            if (bc >= 1 && bc <= 7) drv = tsh[7-bc];
            else if (bc == 8) drv = 1'b1;
            else if (bc == 9) begin
               bc = 0;
               if (!mack) begin
                  tsh = rdb[ti % 4]; ti++; drv = tsh[7];
               end else begin
                  drv = 1'b1; mode = 0;
               end
            end
         end
      end
      ps = scl;
      pd = sda;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic ex(input int v);
      exp_q.push_back(v);
   endtask

   task automatic cmp_log(input string tag, input int base);
      check({tag, " len"}, log_q.size() - base, exp_q.size());
      for (int i = 0; i < exp_q.size() && base + i < log_q.size(); i++)
         check($sformatf("%s[%0d]", tag, i), log_q[base+i], exp_q[i]);
      exp_q.delete();
   endtask

   task automatic run(input logic [15:0] r, input logic isr, input logic [9:0] n, input logic [7:0] d);
      @(negedge clk);
      ra = r; rd = isr; nb = n; di = d; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_ready(input string tag);
      for (int i = 0; i < 5000 && !rdy; i++) @(negedge clk);
      check(tag, rdy, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int base, b0;
      rdb[0] = 8'hBE; rdb[1] = 8'hEF; rdb[2] = 8'h00; rdb[3] = 8'h00;
      repeat (3) @(negedge clk);
      check("rst ready", rdy, 1'b1);
      check("rst error", err, 1'b0);
      check("rst dout", dout, 16'h0);
      check("rst scl_t", scl_t, 1'b1);
      check("rst sda_t", sda_t, 1'b1);
      check("pad drive", {scl_i, sda_i}, 2'b00);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      base = log_q.size(); b0 = nbytes;
      run(16'h1234, 1'b0, 10'd2, 8'hA5);
      check("wr busy", rdy, 1'b0);
      for (int i = 0; i < 3000 && nbytes < b0 + 4; i++) @(negedge clk);
      check("wr sync", nbytes - b0, 4);
      di = 8'h5A;
      wait_ready("wr ready");
      check("wr error", err, 1'b0);
      ex(EV_S); ex('h52); ex('h12); ex('h34); ex('hA5); ex('h5A); ex(EV_P);
      cmp_log("wr log", base);

      base = log_q.size();
      run(16'h0001, 1'b1, 10'd2, 8'h00);
      wait_ready("rd ready");
      check("rd dout", dout, 16'hBEEF);
      check("rd error", err, 1'b0);
      ex(EV_S); ex('h52); ex('h00); ex('h01); ex(EV_S); ex('h53);
      ex(EV_ACK | 0); ex(EV_ACK | 1); ex(EV_P);
      cmp_log("rd log", base);

      nack_addr = 1'b1;
      base = log_q.size();
      run(16'h1234, 1'b0, 10'd2, 8'h11);
      wait_ready("nack ready");
      check("nack error", err, 1'b1);
      ex(EV_S); ex('h52); ex(EV_P);
      cmp_log("nack log", base);
      repeat (20) @(negedge clk);
      check("nack error hold", err, 1'b1);
      check("nack ready hold", rdy, 1'b1);
      nack_addr = 1'b0;

      base = log_q.size();
      @(negedge clk);
      ra = 16'h1234; rd = 1'b0; nb = 10'd0; start = 1'b1;
      @(negedge clk);
      check("nb0 error clr", err, 1'b0);
      check("nb0 busy", rdy, 1'b0);
      for (int i = 0; i < 5000 && !rdy; i++) @(negedge clk);
      check("nb0 ready", rdy, 1'b1);
      start = 1'b0;
      repeat (50) @(negedge clk);
      check("nb0 no retrigger", rdy, 1'b1);
      ex(EV_S); ex('h52); ex('h12); ex('h34); ex(EV_P);
      cmp_log("nb0 log", base);

      run(16'h0001, 1'b1, 10'd2, 8'h00);
      repeat (300) @(negedge clk);
      check("mid busy", rdy, 1'b0);
      check("mid dout kept", dout, 16'hBEEF);
      #2 rst = 1'b1;
      #1;
      check("arst scl_t", scl_t, 1'b1);
      check("arst sda_t", sda_t, 1'b1);
      check("arst ready", rdy, 1'b1);
      check("arst error", err, 1'b0);
      check("arst dout", dout, 16'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
